spi_receptor: RTL and testbench
===============================

# spi_receptor

SPI slave (target) for the four-mode SPI link: the far end of the SPI master already in the design. Samples SCK, CS and MOSI in the CLK domain, shifts a 16-bit word in from MOSI, and simultaneously shifts a parallel-loaded 16-bit word out on MISO. CPOL/CPHA are selected by CKP/CPH. Sits in the testbench loop opposite the master, driven from the same CLK.

## Interface
- `WIDTH`, 16, frame length in bits; MSB first.
- `CLK`  in  1  system clock; all logic is on its rising edge.
- `RESET`  in  1  synchronous, active-low reset.
- `CKP`  in  1  clock polarity (CPOL); SCK idle level.
- `CPH`  in  1  clock phase (CPHA).
- `SCK`  in  1  serial clock from master; synchronous to CLK.
- `CS`  in  1  chip select, active-low.
- `MOSI`  in  1  serial data from master.
- `DATA_TX`  in  WIDTH  word to send; captured at frame start.
- `MISO`  out  1  serial data to master.
- `DATA_RX`  out  WIDTH  last complete received word.
- `RX_VALID`  out  1  one-CLK pulse when DATA_RX updates.
- `BUSY`  out  1  high while a frame is in progress.

## Operation
- Reset (RESET=0 at a CLK edge): state IDLE, MISO=0, DATA_RX=0, RX_VALID=0, BUSY=0, bit counter=0, shift registers=0. Reset overrides everything, including an active frame.
- Registers `sck_q`, `cs_q` hold the previous CLK's values. Edges: rise = SCK & ~sck_q, fall = ~SCK & sck_q; CS fall = ~CS & cs_q.
- Leading edge = rise if CKP=0, fall if CKP=1; trailing edge is the opposite.
- Sample edge: leading if CPH=0, trailing if CPH=1. Shift edge: the other one.
- States:
  - IDLE: MISO=0, BUSY=0. On CS fall: latch CKP/CPH into mode register, load DATA_TX into tx shift register, counter=0, go to XFER. Mode pins are ignored until the next CS fall.
  - XFER: BUSY=1.
    - CPH=0: MISO = tx[WIDTH-1] from the cycle after CS fall.
    - CPH=1: MISO is driven on each shift edge.
    - On sample edge: rx = {rx[WIDTH-2:0], MOSI}, counter++.
    - On shift edge: tx shifts left and MISO takes the new MSB. CPH=1 drives the current MSB first, then shifts.
    - When counter wraps from WIDTH-1 to 0 on a sample edge: DATA_RX <= assembled word, RX_VALID=1 next cycle, tx reloads DATA_TX. CS still low means the next frame is back-to-back.
    - On CS high: go to IDLE, MISO=0. A partial word is discarded: no RX_VALID, DATA_RX unchanged.
- CS rising in the same cycle as a sample edge: the abort wins and the edge is ignored.
- SCK edges while CS is high are ignored.

## Timing
- SCK half-period must be at least 2 CLK cycles.
- Edge detection latency: 1 CLK after SCK changes.
- MISO updates on the CLK edge after the detected shift edge, so it is stable 1 CLK before the master's next sample edge.
- RX_VALID asserts on the CLK edge after the final sample edge and lasts exactly 1 CLK.
- BUSY rises 1 CLK after CS falls and drops 1 CLK after CS rises.
- DATA_TX must be stable at CS fall and at each word boundary.

## Configuration
- `SPI_RX_SYNC_EN` defined: SCK, CS and MOSI pass through a 2-flop synchronizer before edge detection.
  - Adds 2 CLK to every latency above.
  - Required SCK half-period becomes at least 4 CLK cycles.
  - For use with an asynchronous master.
- Undefined: inputs are used directly, with timing as specified above.

## Test plan
- Mode 0 (CKP=0, CPH=0), SCK = CLK/4, DATA_TX=16'hA5C3, master sends 16'h3C5A → DATA_RX=16'h3C5A with one RX_VALID pulse; master receives 16'hA5C3.
- Mode 3 (CKP=1, CPH=1), DATA_TX=16'h8001, MOSI word 16'hFFFE → DATA_RX=16'hFFFE; master receives 16'h8001; MISO=0 after CS rises.
- Modes 1 and 2 with DATA_TX=16'h1234 and MOSI 16'hBEEF → exchange correct in both; changing CKP mid-frame has no effect.
- CS held low for 32 SCK cycles, DATA_TX changed to 16'h5555 after the first word (first word 16'h0F0F) → two RX_VALID pulses; MISO carries 16'h0F0F then 16'h5555.
- CS raised after 7 bits → no RX_VALID, DATA_RX keeps its prior value, BUSY=0 one CLK later; the next full frame is received correctly.
- RESET=0 asserted mid-frame → the next CLK gives MISO=0, BUSY=0, DATA_RX=0, RX_VALID=0; the next frame after release is correct.

Source files
------------

// File: rtl/spi_receptor.sv
// SPI target: shifts a WIDTH-bit word in on MOSI while shifting a parallel-loaded word out on MISO.
// Define SPI_RX_SYNC_EN to pass SCK/CS/MOSI through a 2-flop synchronizer (asynchronous master).
module spi_receptor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CKP,
    input  logic             CPH,
    input  logic             SCK,
    input  logic             CS,
    input  logic             MOSI,
    input  logic [WIDTH-1:0] DATA_TX,
    output logic             MISO,
    output logic [WIDTH-1:0] DATA_RX,
    output logic             RX_VALID,
    output logic             BUSY
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StXfer} state_t;

    state_t           state_q;
    logic             sck_s, cs_s, mosi_s;
    logic             sck_q, cs_q;
    logic             mode_ckp_q, mode_cph_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] rx_q, tx_q;
    logic             sck_rise, sck_fall, cs_fall;
    logic             lead_edge, trail_edge, sample_edge, shift_edge;

`ifdef SPI_RX_SYNC_EN
    logic [2:0] sync1_q, sync2_q;

    always_ff @(posedge CLK) begin
        sync1_q <= {SCK, CS, MOSI};
        sync2_q <= sync1_q;
    end

    assign {sck_s, cs_s, mosi_s} = sync2_q;
`else
    assign {sck_s, cs_s, mosi_s} = {SCK, CS, MOSI};
`endif

    always_ff @(posedge CLK) begin
        sck_q <= sck_s;
        cs_q  <= cs_s;
    end

    assign sck_rise    = sck_s & ~sck_q;
    assign sck_fall    = ~sck_s & sck_q;
    assign cs_fall     = ~cs_s & cs_q;
    assign lead_edge   = mode_ckp_q ? sck_fall : sck_rise;
    assign trail_edge  = mode_ckp_q ? sck_rise : sck_fall;
    assign sample_edge = mode_cph_q ? trail_edge : lead_edge;
    assign shift_edge  = mode_cph_q ? lead_edge : trail_edge;

    // tx_q always holds the bits not yet driven, so every shift edge drives its MSB;
    // for CPH=0 the first bit goes out at frame start and tx_q starts pre-shifted.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= StIdle;
            MISO       <= 1'b0;
            DATA_RX    <= '0;
            RX_VALID   <= 1'b0;
            BUSY       <= 1'b0;
            cnt_q      <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            mode_ckp_q <= 1'b0;
            mode_cph_q <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    MISO <= 1'b0;
                    BUSY <= 1'b0;
                    if (cs_fall) begin
                        mode_ckp_q <= CKP;
                        mode_cph_q <= CPH;
                        cnt_q      <= '0;
                        BUSY       <= 1'b1;
                        state_q    <= StXfer;
                        if (CPH) begin
                            tx_q <= DATA_TX;
                        end else begin
                            MISO <= DATA_TX[WIDTH-1];
                            tx_q <= {DATA_TX[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                StXfer: begin
                    if (cs_s) begin
                        // Abort wins over any coincident edge; a partial word is dropped.
                        state_q <= StIdle;
                        MISO    <= 1'b0;
                        BUSY    <= 1'b0;
                    end else if (sample_edge) begin
                        rx_q <= {rx_q[WIDTH-2:0], mosi_s};
                        if (cnt_q == LastBit) begin
                            cnt_q    <= '0;
                            DATA_RX  <= {rx_q[WIDTH-2:0], mosi_s};
                            RX_VALID <= 1'b1;
                            tx_q     <= DATA_TX;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (shift_edge) begin
                        MISO <= tx_q[WIDTH-1];
                        tx_q <= {tx_q[WIDTH-2:0], 1'b0};
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_receptor.sv
// Randomized bench for spi_receptor: a bit-level SPI master plus a word-level model of the exchange.
module tb_spi_receptor;

`ifdef SPI_RX_SYNC_EN
    localparam int Lat  = 3;
    localparam int HMin = 4;
`else
    localparam int Lat  = 1;
    localparam int HMin = 2;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        CKP = 1'b0;
    logic        CPH = 1'b0;
    logic        SCK = 1'b0;
    logic        CS = 1'b1;
    logic        MOSI = 1'b0;
    logic [15:0] DATA_TX = '0;
    logic        MISO;
    logic [15:0] DATA_RX;
    logic        RX_VALID;
    logic        BUSY;

    int          total = 0;
    int          bad = 0;
    int          h = HMin;
    int          long_pulse = 0;
    logic        valid_prev = 1'b0;
    logic [15:0] got_q[$];
    logic [15:0] exp_data_rx = '0;

    spi_receptor #(.WIDTH(16)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .CKP      (CKP),
        .CPH      (CPH),
        .SCK      (SCK),
        .CS       (CS),
        .MOSI     (MOSI),
        .DATA_TX  (DATA_TX),
        .MISO     (MISO),
        .DATA_RX  (DATA_RX),
        .RX_VALID (RX_VALID),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    // Record every received word; a pulse lasting two samples counts as too long.
    always @(negedge CLK) begin
        if (RX_VALID) got_q.push_back(DATA_RX);
        if (RX_VALID && valid_prev) long_pulse++;
        valid_prev <= RX_VALID;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Master side: nbits bits of mosi_bits (MSB first) clocked out; returns what MISO carried.
    task automatic run_frame(input bit ckp, input bit cpha, input int nbits,
                             input logic [31:0] mosi_bits, input logic [15:0] tx0,
                             input logic [15:0] tx1, input bit flip,
                             output logic [31:0] miso_bits);
        CKP = ckp;
        CPH = cpha;
        SCK = ckp;
        DATA_TX = tx0;
        MOSI = 1'b0;
        tick(2);
        if (!cpha) MOSI = mosi_bits[nbits-1];
        CS = 1'b0;
        tick(Lat);
        check("busy_rise", BUSY, 1);
        tick(h - Lat);
        miso_bits = '0;
        for (int k = 0; k < nbits; k++) begin
            if (k == 1) DATA_TX = tx1;
            if (flip && k == 4) CKP = ~ckp;
            if (cpha) MOSI = mosi_bits[nbits-1-k];
            else miso_bits = {miso_bits[30:0], MISO};
            SCK = ~ckp;
            tick(h);
            if (cpha) miso_bits = {miso_bits[30:0], MISO};
            else if (k + 1 < nbits) MOSI = mosi_bits[nbits-2-k];
            SCK = ckp;
            tick(h);
        end
        CS = 1'b1;
        tick(Lat);
        check("busy_fall", BUSY, 0);
        check("miso_idle", MISO, 0);
    endtask

    // Word-level expectations: complete 16-bit groups are received, the rest is dropped;
    // MISO carries tx0 then tx1 in order.
    task automatic do_frame(input bit ckp, input bit cpha, input int nbits,
                            input logic [31:0] mosi_bits, input logic [15:0] tx0,
                            input logic [15:0] tx1, input bit flip);
        logic [31:0] miso_bits;
        logic [31:0] full;
        logic [15:0] w;
        int          nwords;
        got_q.delete();
        run_frame(ckp, cpha, nbits, mosi_bits, tx0, tx1, flip, miso_bits);
        nwords = nbits / 16;
        full = {tx0, tx1};
        check("miso_word", miso_bits, full >> (32 - nbits));
        check("rx_count", got_q.size(), nwords);
        for (int j = 0; j < nwords; j++) begin
            w = 16'(mosi_bits >> (nbits - 16 * (j + 1)));
            if (j < got_q.size()) check("rx_word", got_q[j], w);
            exp_data_rx = w;
        end
        check("data_rx", DATA_RX, exp_data_rx);
        check("pulse_width", long_pulse, 0);
    endtask

    initial begin
        RESET = 1'b0;
        tick(3);
        check("rst_miso", MISO, 0);
        check("rst_busy", BUSY, 0);
        check("rst_data_rx", DATA_RX, 0);
        check("rst_rx_valid", RX_VALID, 0);
        RESET = 1'b1;
        tick(2);

        h = HMin;
        do_frame(1'b0, 1'b0, 16, 32'h0000_3C5A, 16'hA5C3, 16'hA5C3, 1'b0);
        do_frame(1'b1, 1'b1, 16, 32'h0000_FFFE, 16'h8001, 16'h8001, 1'b0);
        do_frame(1'b0, 1'b1, 16, 32'h0000_BEEF, 16'h1234, 16'h1234, 1'b1);
        do_frame(1'b1, 1'b0, 16, 32'h0000_BEEF, 16'h1234, 16'h1234, 1'b1);
        do_frame(1'b0, 1'b0, 32, 32'hC0DE_1357, 16'h0F0F, 16'h5555, 1'b0);
        do_frame(1'b1, 1'b1, 32, 32'h9A3C_E771, 16'h0F0F, 16'h5555, 1'b0);
        do_frame(1'b0, 1'b0, 7, 32'h0000_0055, 16'hF00D, 16'hF00D, 1'b0);
        do_frame(1'b0, 1'b0, 16, 32'h0000_6B2D, 16'h4C11, 16'h4C11, 1'b0);

        // Reset in the middle of a frame while MISO is driving ones.
        CKP = 1'b0;
        CPH = 1'b0;
        SCK = 1'b0;
        MOSI = 1'b1;
        DATA_TX = 16'hFFFF;
        CS = 1'b0;
        tick(h);
        for (int i = 0; i < 5; i++) begin
            SCK = 1'b1;
            tick(h);
            SCK = 1'b0;
            tick(h);
        end
        RESET = 1'b0;
        tick(1);
        check("midrst_miso", MISO, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_data_rx", DATA_RX, 0);
        check("midrst_rx_valid", RX_VALID, 0);
        RESET = 1'b1;
        CS = 1'b1;
        tick(4);
        exp_data_rx = '0;
        do_frame(1'b0, 1'b0, 16, 32'h0000_D00F, 16'h7E81, 16'h7E81, 1'b0);

        for (int n = 0; n < 12; n++) begin
            int          sel;
            int          nbits;
            logic [31:0] mosi_bits;
            logic [15:0] tx0;
            logic [15:0] tx1;
            h = HMin + int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 3));
            nbits = (sel == 0) ? int'($urandom_range(1, 31)) : (sel == 3) ? 32 : 16;
            mosi_bits = $urandom;
            tx0 = 16'($urandom);
            tx1 = 16'($urandom);
            do_frame(1'($urandom), 1'($urandom), nbits, mosi_bits, tx0, tx1, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
